st_ctrl_seq: RTL and testbench
==============================

Name: st_ctrl_seq

Overview:
- Hardware control sequencer for the store instruction (`st Ra, C(Rb)`): executes the write direction of memory access, the counterpart of the load sequence.
- Drives the datapath's one-hot `enable`/`busSelect` vectors, `Control_Signals`, register-select strobes and RAM strobes through fetch, effective-address and write phases.
- Sits between the top-level control unit (`start`/`done` handshake) and the datapath/RAM (`mem_ready` wait handshake).

Parameters:
TIMEOUT_CYCLES, 15, wait-state cycles allowed per memory access before abort (used only with ST_MEM_TIMEOUT_EN)
ST_OPCODE, 5'b00010, value of ir[31:27] identifying st

Ports:
clk  in  1  system clock, all state on rising edge
clr  in  1  synchronous active-low reset
start  in  1  begin one store instruction; sampled only in IDLE
ir  in  32  IR contents from datapath, checked in T3
mem_ready  in  1  RAM access complete this cycle
enable  out  32  datapath register load enables, one-hot per phase
busSelect  out  32  bus source selects
Control_Signals  out  5  ALU op (14=IncPC, 1=ADD, 0=none)
MD_Read  out  1  MDR input mux: 1=RAM, 0=bus
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select logic strobes
ReadRAM, WriteRAM  out  1 each  RAM strobes
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of instruction
illegal  out  1  valid with done: fetched opcode != ST_OPCODE
timeout  out  1  valid with done: memory wait exceeded (0 if feature off)

Behaviour:
- Reset: clr low at a rising edge forces IDLE and clears the wait counter; every output is 0 in the following cycle. Reset is honoured in every state, including mid-instruction and mid-wait; RAM strobes drop immediately.
- Outputs are a Moore decode of the state register: stable for the whole cycle a state is held. Every bit not listed for a state is 0.
- States and outputs:
  - IDLE: all 0. start=1 -> T0; otherwise stay.
  - T0: busSelect[20] (PCout), enable[25] (MARin), enable[18] (Zin), Control_Signals=14. -> T1.
  - T1: busSelect[19] (Zlowout), enable[20] (PCin), enable[21] (MDRin), MD_Read=1, ReadRAM=1. Held until mem_ready=1, then -> T2.
  - T2: busSelect[21] (MDRout), enable[24] (IRin). -> T3.
  - T3: Grb, BAout, Rout, enable[19] (Yin). If ir[31:27] != ST_OPCODE -> DONE with illegal set; otherwise -> T4.
  - T4: busSelect[23] (Cout), Control_Signals=1, enable[18]. -> T5.
  - T5: busSelect[19], enable[25]. -> T6.
  - T6: Gra, Rout, enable[21], MD_Read=0 (Ra into MDR from bus). -> T7.
  - T7: WriteRAM=1. Held until mem_ready=1, then -> DONE.
  - DONE: done=1; illegal/timeout show the latched cause. -> IDLE.
- Latency: with mem_ready tied high, start sampled at edge k gives T0 in cycle k+1 and done in cycle k+9 (9 states). Each extra wait cycle in T1 or T7 adds 1.
- start while busy is ignored, with no queuing. start held high in the DONE cycle is not seen; it is sampled again in IDLE on the next cycle.
- mem_ready outside T1/T7 is ignored. illegal and timeout are cleared on entry to T0.
- Wait counter: 4+ bits, counts cycles spent in T1/T7, reset to 0 on entering either state.

Optional Feature:
- Macro: ST_MEM_TIMEOUT_EN.
- Defined: if the wait counter reaches TIMEOUT_CYCLES while in T1 or T7 with mem_ready=0, go to DONE with timeout=1. RAM strobes deassert on that edge. mem_ready arriving in the same cycle the limit is reached takes priority (normal completion).
- Undefined: no counter is synthesised, timeout is tied 0, and waits are unbounded.

Test Plan:
- Reset then zero-wait store (mem_ready=1, ir=32'h1100_0005): start at cycle 0 -> T0..T7 decoded exactly as listed, WriteRAM high one cycle (cycle 8), done=1 at cycle 9, illegal=0, busy falls at cycle 10.
- Wait states: mem_ready low 3 cycles in T1 and 2 cycles in T7 -> ReadRAM high 4 cycles, WriteRAM high 3 cycles, done at cycle 14.
- Illegal opcode: ir=32'h0080_0000 (ld) -> sequence stops after T3, no T4–T7 outputs, done=1 and illegal=1 at cycle 5, WriteRAM never asserted.
- Reset mid-wait: clr low during T7 wait -> all outputs 0 next cycle, done never pulses. A fresh start then completes normally.
- start pulses at cycles 3 and 9 during an active instruction -> ignored, exactly one done. start in the IDLE cycle after done launches the second instruction.
- ST_MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ready stuck 0 in T1 -> DONE after 4 wait cycles with timeout=1. Second run with mem_ready rising on the 4th cycle -> normal completion, timeout=0.

Source files
------------

// File: rtl/st_ctrl_seq_if.sv
// Store sequencer bundle: control-unit handshake, IR, RAM wait and datapath strobes.
// Latency: none (wires only).
// Backpressure: mem_ready holds the sequencer in its RAM states; start is ignored while busy.
interface st_ctrl_seq_if;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [4:0]  Control_Signals;
  logic        MD_Read;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        ReadRAM;
  logic        WriteRAM;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        timeout;

  // Sequencer side
  modport slave (
    input  start, ir, mem_ready,
    output enable, busSelect, Control_Signals, MD_Read,
           Gra, Grb, Grc, Rin, Rout, BAout,
           ReadRAM, WriteRAM, busy, done, illegal, timeout
  );

  // Control unit / datapath side
  modport master (
    output start, ir, mem_ready,
    input  enable, busSelect, Control_Signals, MD_Read,
           Gra, Grb, Grc, Rin, Rout, BAout,
           ReadRAM, WriteRAM, busy, done, illegal, timeout
  );
endinterface

// File: rtl/st_ctrl_seq.sv
// Store-instruction control sequencer (fetch, EA, write); optional RAM timeout via ST_MEM_TIMEOUT_EN.
// Latency: start -> done in 9 cycles with no RAM waits, +1 per wait cycle in T1/T7.
// Backpressure: holds T1/T7 until mem_ready; start ignored while busy (no queuing).
module st_ctrl_seq #(
  parameter int         TIMEOUT_CYCLES = 15,
  parameter logic [4:0] ST_OPCODE      = 5'b00010
) (
  input  logic         clk,
  input  logic         clr,
  st_ctrl_seq_if.slave io
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_illegal;
  logic   w_in_wait;
  logic   w_bad_opcode;
  logic   w_wait_expired;
  logic   w_timeout_flag;
  logic   w_unused_ir;

  // Only the opcode field matters here; the rest of IR belongs to the datapath.
  assign w_unused_ir  = &{1'b0, io.ir[26:0]};
  assign w_in_wait    = (r_state == S_T1) || (r_state == S_T7);
  assign w_bad_opcode = (io.ir[31:27] != ST_OPCODE);

`ifdef ST_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  // Counter holds the number of completed wait cycles, so the limit is hit
  // on the TIMEOUT_CYCLES-th cycle spent in the RAM state. mem_ready wins.
  assign w_wait_expired = w_in_wait && !io.mem_ready &&
                          (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_timeout_flag = r_timeout;

  // Wait counter restarts on every entry to T1/T7; timeout cause cleared on entry to T0.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_in_wait && (w_next_state == r_state)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_next_state == S_T0) begin
        r_timeout <= 1'b0;
      end else if (w_wait_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  // Waits are unbounded; the parameter only sizes the optional counter.
  localparam bit TimeoutConfigured = (TIMEOUT_CYCLES > 0);

  assign w_wait_expired = 1'b0;
  assign w_timeout_flag = 1'b0 & TimeoutConfigured;
`endif

  // State register and latched illegal-opcode cause.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == S_T0) begin
        r_illegal <= 1'b0;
      end else if ((r_state == S_T3) && w_bad_opcode) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state decode; RAM states hold until mem_ready (or the optional timeout).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (io.start) w_next_state = S_T0;
      S_T0:   w_next_state = S_T1;
      S_T1: begin
        if (io.mem_ready)        w_next_state = S_T2;
        else if (w_wait_expired) w_next_state = S_DONE;
      end
      S_T2:   w_next_state = S_T3;
      S_T3:   w_next_state = w_bad_opcode ? S_DONE : S_T4;
      S_T4:   w_next_state = S_T5;
      S_T5:   w_next_state = S_T6;
      S_T6:   w_next_state = S_T7;
      S_T7: begin
        if (io.mem_ready || w_wait_expired) w_next_state = S_DONE;
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore output decode: every strobe is a pure function of the state register.
  always_comb begin
    io.enable          = '0;
    io.busSelect       = '0;
    io.Control_Signals = 5'd0;
    io.MD_Read         = 1'b0;
    io.Gra             = 1'b0;
    io.Grb             = 1'b0;
    io.Grc             = 1'b0;
    io.Rin             = 1'b0;
    io.Rout            = 1'b0;
    io.BAout           = 1'b0;
    io.ReadRAM         = 1'b0;
    io.WriteRAM        = 1'b0;
    io.busy            = (r_state != S_IDLE);
    io.done            = 1'b0;
    io.illegal         = 1'b0;
    io.timeout         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
      end
      // PC -> MAR, PC+1 -> Z
      S_T0: begin
        io.busSelect[20]   = 1'b1;
        io.enable[25]      = 1'b1;
        io.enable[18]      = 1'b1;
        io.Control_Signals = 5'd14;
      end
      // Z -> PC, RAM -> MDR
      S_T1: begin
        io.busSelect[19] = 1'b1;
        io.enable[20]    = 1'b1;
        io.enable[21]    = 1'b1;
        io.MD_Read       = 1'b1;
        io.ReadRAM       = 1'b1;
      end
      // MDR -> IR
      S_T2: begin
        io.busSelect[21] = 1'b1;
        io.enable[24]    = 1'b1;
      end
      // Rb (or 0 when Rb=R0) -> Y
      S_T3: begin
        io.Grb        = 1'b1;
        io.BAout      = 1'b1;
        io.Rout       = 1'b1;
        io.enable[19] = 1'b1;
      end
      // Y + C -> Z
      S_T4: begin
        io.busSelect[23]   = 1'b1;
        io.Control_Signals = 5'd1;
        io.enable[18]      = 1'b1;
      end
      // Z -> MAR (effective address)
      S_T5: begin
        io.busSelect[19] = 1'b1;
        io.enable[25]    = 1'b1;
      end
      // Ra -> MDR from the bus
      S_T6: begin
        io.Gra        = 1'b1;
        io.Rout       = 1'b1;
        io.enable[21] = 1'b1;
      end
      // MDR -> RAM[MAR]
      S_T7: begin
        io.WriteRAM = 1'b1;
      end
      S_DONE: begin
        io.done    = 1'b1;
        io.illegal = r_illegal;
        io.timeout = w_timeout_flag;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_st_ctrl_seq.sv
// Scoreboard bench for st_ctrl_seq: per-cycle expected strobe vectors queued by stimulus.
// Latency: checks every cycle from T0 to DONE plus all-zero idle cycles.
// Backpressure: mem_ready wait patterns driven per cycle from the stimulus tables.
module tb_st_ctrl_seq;

  localparam int TO = 4;
  localparam logic [31:0] IR_ST = 32'h1100_0005;
  localparam logic [31:0] IR_LD = 32'h0080_0000;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic [4:0]  cs;
    logic        md_read;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic        baout;
    logic        rd;
    logic        wr;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        timeout;
  } snap_t;

  logic clk;
  logic clr;
  st_ctrl_seq_if bus ();

  st_ctrl_seq #(
    .TIMEOUT_CYCLES(TO),
    .ST_OPCODE     (5'b00010)
  ) dut (
    .clk(clk),
    .clr(clr),
    .io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;
  snap_t expq[$];
  int    codeq[$];
  snap_t act_s;
  snap_t exp_s;
  int    exp_code;

  // Hand-written strobe table: state code 0=IDLE, 1..8=T0..T7, 9=DONE.
  function automatic snap_t exp_vec(input int code, input bit ill, input bit to);
    snap_t s;
    s = '0;
    s.busy = (code != 0);
    case (code)
      1: begin s.bs[20] = 1'b1; s.en[25] = 1'b1; s.en[18] = 1'b1; s.cs = 5'd14; end
      2: begin s.bs[19] = 1'b1; s.en[20] = 1'b1; s.en[21] = 1'b1; s.md_read = 1'b1; s.rd = 1'b1; end
      3: begin s.bs[21] = 1'b1; s.en[24] = 1'b1; end
      4: begin s.grb = 1'b1; s.baout = 1'b1; s.rout = 1'b1; s.en[19] = 1'b1; end
      5: begin s.bs[23] = 1'b1; s.cs = 5'd1; s.en[18] = 1'b1; end
      6: begin s.bs[19] = 1'b1; s.en[25] = 1'b1; end
      7: begin s.gra = 1'b1; s.rout = 1'b1; s.en[21] = 1'b1; end
      8: begin s.wr = 1'b1; end
      9: begin s.done = 1'b1; s.illegal = ill; s.timeout = to; end
      default: begin end
    endcase
    return s;
  endfunction

  function automatic snap_t get_snap();
    snap_t s;
    s.en = bus.enable;       s.bs = bus.busSelect;   s.cs = bus.Control_Signals;
    s.md_read = bus.MD_Read; s.gra = bus.Gra;        s.grb = bus.Grb;
    s.grc = bus.Grc;         s.rin = bus.Rin;        s.rout = bus.Rout;
    s.baout = bus.BAout;     s.rd = bus.ReadRAM;     s.wr = bus.WriteRAM;
    s.busy = bus.busy;       s.done = bus.done;      s.illegal = bus.illegal;
    s.timeout = bus.timeout;
    return s;
  endfunction

  // Monitor: away from the active edge, pop one expected vector per busy cycle,
  // otherwise require the all-zero idle decode.
  always @(negedge clk) begin
    if (mon_en) begin
      act_s = get_snap();
      if (expq.size() > 0) begin
        exp_s    = expq.pop_front();
        exp_code = codeq.pop_front();
      end else begin
        exp_s    = '0;
        exp_code = 0;
      end
      total++;
      if (act_s !== exp_s) begin
        bad++;
        $display("FAIL step state=%0d t=%0t got=%h want=%h", exp_code, $time, act_s, exp_s);
      end
    end
  end

  // One instruction: build the expected per-cycle table and mem_ready/start pattern,
  // launch from IDLE, then drive the pattern cycle by cycle. abort_idx pulls clr low.
  task automatic run(input logic [31:0] ir_v, input int w1, input int w7, input bit to1,
                     input logic [31:0] smask, input int abort_idx);
    snap_t seq[$];
    int    codes[$];
    bit    mr[$];
    bit    ill;
    ill = (ir_v[31:27] != 5'b00010);
    seq.push_back(exp_vec(1, 0, 0)); codes.push_back(1); mr.push_back(1'b1);
    if (to1) begin
      repeat (TO) begin seq.push_back(exp_vec(2, 0, 0)); codes.push_back(2); mr.push_back(1'b0); end
      seq.push_back(exp_vec(9, 0, 1)); codes.push_back(9); mr.push_back(1'b0);
    end else begin
      repeat (w1) begin seq.push_back(exp_vec(2, 0, 0)); codes.push_back(2); mr.push_back(1'b0); end
      seq.push_back(exp_vec(2, 0, 0)); codes.push_back(2); mr.push_back(1'b1);
      seq.push_back(exp_vec(3, 0, 0)); codes.push_back(3); mr.push_back(1'b1);
      seq.push_back(exp_vec(4, 0, 0)); codes.push_back(4); mr.push_back(1'b1);
      if (ill) begin
        seq.push_back(exp_vec(9, 1, 0)); codes.push_back(9); mr.push_back(1'b1);
      end else begin
        for (int c = 5; c <= 7; c++) begin
          seq.push_back(exp_vec(c, 0, 0)); codes.push_back(c); mr.push_back(1'b1);
        end
        repeat (w7) begin seq.push_back(exp_vec(8, 0, 0)); codes.push_back(8); mr.push_back(1'b0); end
        seq.push_back(exp_vec(8, 0, 0)); codes.push_back(8); mr.push_back(1'b1);
        seq.push_back(exp_vec(9, 0, 0)); codes.push_back(9); mr.push_back(1'b1);
      end
    end
    bus.ir    = ir_v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    foreach (seq[k]) begin
      expq.push_back(seq[k]);
      codeq.push_back(codes[k]);
    end
    for (int i = 0; i < seq.size(); i++) begin
      bus.start     = smask[i];
      bus.mem_ready = mr[i];
      if (i == abort_idx) clr = 1'b0;
      @(posedge clk); #1;
      if (i == abort_idx) begin
        expq.delete();
        codeq.delete();
        clr           = 1'b1;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        return;
      end
    end
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    clr           = 1'b0;
    bus.start     = 1'b0;
    bus.ir        = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;

    // Zero-wait store: done 9 cycles after start, busy gone the cycle after.
    run(IR_ST, 0, 0, 1'b0, 32'h0, -1);
    @(posedge clk); #1;
    // RAM waits: 3 in T1, 2 in T7 -> done 14 cycles after start.
    run(IR_ST, 3, 2, 1'b0, 32'h0, -1);
    @(posedge clk); #1;
    // Load opcode: stops after T3 with illegal flagged.
    run(IR_LD, 0, 0, 1'b0, 32'h0, -1);
    @(posedge clk); #1;
    // Reset during the T7 wait (third T7 cycle), then a clean store.
    run(IR_ST, 0, 5, 1'b0, 32'h0, 9);
    @(posedge clk); #1;
    run(IR_ST, 1, 1, 1'b0, 32'h0, -1);
    @(posedge clk); #1;
    // Stray start pulses in T2 and DONE are ignored; next start in the IDLE cycle.
    run(IR_ST, 0, 0, 1'b0, (32'h1 << 2) | (32'h1 << 8), -1);
    run(IR_ST, 0, 0, 1'b0, 32'h0, -1);
    @(posedge clk); #1;
`ifdef ST_MEM_TIMEOUT_EN
    // RAM never answers in T1: abort after TO cycles with timeout.
    run(IR_ST, 0, 0, 1'b1, 32'h0, -1);
    @(posedge clk); #1;
    // mem_ready on the TO-th cycle completes normally.
    run(IR_ST, TO - 1, 0, 1'b0, 32'h0, -1);
    @(posedge clk); #1;
`endif
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
